axi_mm_beat_capture: RTL and testbench
======================================

// Module: axi_mm_beat_capture
// PURPOSE
//  Monitors one AXI-MM data channel (W or R) and captures the first and last beats of one
//  burst. Feeds the CSR block's data_out_*/data_in_* capture registers; one instance per channel.
//  Also checks the observed burst length against the programmed length and counts completed bursts.
//  Arm/re-arm is by a CSR-driven synchronous clear.
// PARAMETERS
//  DATA_WIDTH  128  width of the monitored data bus and of both capture registers
//  LEN_WIDTH   8    width of the AXI length field; beats per burst = expected_len+1
// PORTS
//  clk               in   1           single clock for all logic
//  rst               in   1           asynchronous reset, active-high
//  clr               in   1           synchronous clear/re-arm pulse from CSR
//  capture_en        in   1           beats are observed only while high
//  expected_len      in   LEN_WIDTH   programmed AXI length (aximm_rw_length)
//  s_valid           in   1           monitored channel VALID
//  s_ready           in   1           monitored channel READY
//  s_data            in   DATA_WIDTH  monitored channel DATA
//  s_last            in   1           monitored channel LAST
//  data_first        out  DATA_WIDTH  captured first beat of the burst
//  data_first_valid  out  1           data_first holds a captured beat
//  data_last         out  DATA_WIDTH  captured last beat of the burst
//  data_last_valid   out  1           data_last holds a captured beat
//  beat_cnt          out  LEN_WIDTH+1 beats accepted in the current/captured burst
//  burst_cnt         out  16          completed bursts (LAST handshakes) since clear
//  len_error         out  1           sticky: observed length != expected_len+1
// BEHAVIOUR
//  - Beat = s_valid & s_ready & capture_en in one cycle. Monitor only; never drives the channel.
//  - All outputs registered, zero on rst and on clr. Update 1 cycle after the beat.
//  - FSM states:
//    - IDLE: first beat -> data_first=s_data, data_first_valid=1, beat_cnt=1.
//      If s_last is also high: data_last=s_data, data_last_valid=1 -> DONE; else -> BURST.
//    - BURST: each beat increments beat_cnt. Beat with s_last: data_last=s_data,
//      data_last_valid=1 -> DONE.
//    - DONE: captures and beat_cnt are frozen. Further beats are ignored except burst_cnt.
//      Only clr or rst returns to IDLE.
//  - burst_cnt: +1 on every beat with s_last in any state. Saturates at 16'hFFFF.
//  - beat_cnt saturates at all-ones and does not wrap.
//  - len_error (captured burst only, sticky until clr/rst); set in the cycle after:
//    - a LAST beat with (beat count including it) != expected_len+1, or
//    - a non-LAST beat that makes the count exceed expected_len+1 (flag set before LAST arrives).
//  - expected_len is sampled on every beat; CSR keeps it stable while armed.
//  - clr in the same cycle as a beat: clr wins, the beat is dropped, next state is IDLE.
//  - capture_en low mid-burst: state and registers hold; the burst resumes when it returns high.
//  - rst asserted mid-burst: asynchronous return to IDLE with all outputs 0.
//    After rst deasserts, capture starts on the next beat even if it is mid-burst upstream.
// TESTING
//  1. expected_len=3, 4 beats D0..D3, LAST on D3 -> first=D0, last=D3, beat_cnt=4,
//     burst_cnt=1, len_error=0.
//  2. expected_len=0, single beat 0xAA with LAST -> first=last=0xAA, both valids high 1 cycle later.
//  3. expected_len=3, LAST on beat 2 -> len_error=1, beat_cnt=2.
//     Then clr -> all outputs 0, state IDLE.
//  4. expected_len=1, 3 beats without LAST -> len_error=1 after beat 3. DONE not reached.
//  5. In DONE, send 2 more bursts -> captures unchanged, burst_cnt=3.
//     clr coincident with a beat -> beat not captured.
//  6. Random valid/ready stalls and capture_en toggling mid-burst -> captures match a scoreboard.
//     rst mid-burst -> outputs 0 asynchronously.

Source files
------------

// File: rtl/axi_mm_beat_capture.sv
// Passive AXI-MM beat monitor: captures first/last beat of one burst, checks its length, counts bursts.
// All outputs registered, updated 1 cycle after the beat; never drives VALID/READY, so no backpressure.
module axi_mm_beat_capture #(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  capture_en,
    input  logic [LEN_WIDTH-1:0]  expected_len,
    input  logic                  s_valid,
    input  logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] data_first,
    output logic                  data_first_valid,
    output logic [DATA_WIDTH-1:0] data_last,
    output logic                  data_last_valid,
    output logic [LEN_WIDTH:0]    beat_cnt,
    output logic [15:0]           burst_cnt,
    output logic                  len_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH:0] CNT_MAX   = '1;
    localparam logic [15:0]        BURST_MAX = 16'hFFFF;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   data_first_nxt, data_last_nxt;
    logic                    data_first_valid_nxt, data_last_valid_nxt;
    logic [LEN_WIDTH:0]      beat_cnt_nxt;
    logic [15:0]             burst_cnt_nxt;
    logic                    len_error_nxt;

    logic                    beat;
    logic [LEN_WIDTH:0]      exp_beats;
    logic [LEN_WIDTH:0]      cnt_inc;

    assign beat      = s_valid & s_ready & capture_en;
    assign exp_beats = {1'b0, expected_len} + (LEN_WIDTH+1)'(1);

    // Count of the burst including the current beat, saturating rather than wrapping.
    always_comb begin
        cnt_inc = (LEN_WIDTH+1)'(1);
        if (state != IDLE) begin
            cnt_inc = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + (LEN_WIDTH+1)'(1);
        end
    end

    always_comb begin
        state_nxt            = state;
        data_first_nxt       = data_first;
        data_first_valid_nxt = data_first_valid;
        data_last_nxt        = data_last;
        data_last_valid_nxt  = data_last_valid;
        beat_cnt_nxt         = beat_cnt;
        burst_cnt_nxt        = burst_cnt;
        len_error_nxt        = len_error;

        if (beat) begin
            if (s_last && (burst_cnt != BURST_MAX)) begin
                burst_cnt_nxt = burst_cnt + 16'd1;
            end
            // DONE freezes the capture; only burst_cnt keeps tracking traffic.
            if (state != DONE) begin
                beat_cnt_nxt = cnt_inc;
                if (state == IDLE) begin
                    data_first_nxt       = s_data;
                    data_first_valid_nxt = 1'b1;
                    state_nxt            = BURST;
                end
                if (s_last) begin
                    data_last_nxt       = s_data;
                    data_last_valid_nxt = 1'b1;
                    state_nxt           = DONE;
                    if (cnt_inc != exp_beats) begin
                        len_error_nxt = 1'b1;
                    end
                end else if (cnt_inc > exp_beats) begin
                    len_error_nxt = 1'b1;
                end
            end
        end

        // Re-arm wins over a coincident beat.
        if (clr) begin
            state_nxt            = IDLE;
            data_first_nxt       = '0;
            data_first_valid_nxt = 1'b0;
            data_last_nxt        = '0;
            data_last_valid_nxt  = 1'b0;
            beat_cnt_nxt         = '0;
            burst_cnt_nxt        = '0;
            len_error_nxt        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_first       <= '0;
            data_first_valid <= 1'b0;
            data_last        <= '0;
            data_last_valid  <= 1'b0;
            beat_cnt         <= '0;
            burst_cnt        <= '0;
            len_error        <= 1'b0;
        end else begin
            data_first       <= data_first_nxt;
            data_first_valid <= data_first_valid_nxt;
            data_last        <= data_last_nxt;
            data_last_valid  <= data_last_valid_nxt;
            beat_cnt         <= beat_cnt_nxt;
            burst_cnt        <= burst_cnt_nxt;
            len_error        <= len_error_nxt;
        end
    end

endmodule

// File: tb/tb_axi_mm_beat_capture.sv
// Bench for axi_mm_beat_capture: a beat-level reference model pushes the expected output
// snapshot every cycle; each scenario task drains and compares it, plus fixed-value checks.
module tb_axi_mm_beat_capture;

    localparam int DW = 128;
    localparam int LW = 8;

    typedef struct packed {
        logic [DW-1:0] first;
        logic          fv;
        logic [DW-1:0] last;
        logic          lv;
        logic [LW:0]   bc;
        logic [15:0]   bu;
        logic          le;
    } snap_t;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          capture_en;
    logic [LW-1:0] expected_len;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic [DW-1:0] data_first;
    logic          data_first_valid;
    logic [DW-1:0] data_last;
    logic          data_last_valid;
    logic [LW:0]   beat_cnt;
    logic [15:0]   burst_cnt;
    logic          len_error;

    int    errors = 0;
    int    checks = 0;
    snap_t exp_q[$];
    snap_t obs_q[$];
    snap_t m;
    int    m_state;
    snap_t e, o;

    axi_mm_beat_capture #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk              (clk),
        .rst              (rst),
        .clr              (clr),
        .capture_en       (capture_en),
        .expected_len     (expected_len),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_last           (s_last),
        .data_first       (data_first),
        .data_first_valid (data_first_valid),
        .data_last        (data_last),
        .data_last_valid  (data_last_valid),
        .beat_cnt         (beat_cnt),
        .burst_cnt        (burst_cnt),
        .len_error        (len_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t obs_snap();
        return {data_first, data_first_valid, data_last, data_last_valid, beat_cnt, burst_cnt, len_error};
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock of stimulus; the model advances at the edge, outputs are sampled 1 ns later.
    task automatic drive_cycle(input logic v, input logic r, input logic l, input logic en,
                               input logic c, input logic [DW-1:0] d);
        int n;
        s_valid = v; s_ready = r; s_last = l; capture_en = en; clr = c; s_data = d;
        @(posedge clk);
        if (c) begin
            m = '0;
            m_state = 0;
        end else if (v && r && en) begin
            if (l && m.bu != 16'hFFFF) m.bu = m.bu + 16'd1;
            if (m_state != 2) begin
                n = (m_state == 0) ? 1 : ((int'(m.bc) == 511) ? 511 : int'(m.bc) + 1);
                m.bc = n[LW:0];
                if (m_state == 0) begin
                    m.first = d; m.fv = 1'b1; m_state = 1;
                end
                if (l) begin
                    m.last = d; m.lv = 1'b1; m_state = 2;
                    if (n != int'(expected_len) + 1) m.le = 1'b1;
                end else if (n > int'(expected_len) + 1) begin
                    m.le = 1'b1;
                end
            end
        end
        #1;
        exp_q.push_back(m);
        obs_q.push_back(obs_snap());
        s_valid = 1'b0; clr = 1'b0; s_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; capture_en = 1'b0; expected_len = '0;
        s_valid = 1'b0; s_ready = 1'b0; s_data = '0; s_last = 1'b0;
        m = '0; m_state = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_snap() !== snap_t'(0)) begin
            errors++; $display("FAIL reset_active: got %h want 0", obs_snap());
        end
        rst = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_sb: got %h want %h", o, e); end
        end
    endtask

    // Four beats D0..D3 with LAST on D3 against expected_len=3.
    task automatic test_basic_burst();
        logic [DW-1:0] d [4];
        expected_len = 8'd3;
        for (int i = 0; i < 4; i++) d[i] = rnd_data();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, i == 3, 1'b1, 1'b0, d[i]);
        checks++;
        if (data_first !== d[0] || data_last !== d[3] || beat_cnt !== 9'd4 ||
            burst_cnt !== 16'd1 || len_error !== 1'b0 || !data_first_valid || !data_last_valid) begin
            errors++;
            $display("FAIL basic_burst: got first=%h last=%h beats=%0d bursts=%0d err=%b want first=%h last=%h beats=4 bursts=1 err=0",
                     data_first, data_last, beat_cnt, burst_cnt, len_error, d[0], d[3]);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL basic_sb: got %h want %h", o, e); end
        end
    endtask

    // Runs from DONE left by test_basic_burst: two extra bursts, then clr racing a beat.
    task automatic test_done_freeze();
        logic [DW-1:0] f0, l0, dn;
        f0 = data_first; l0 = data_last;
        for (int b = 0; b < 2; b++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rnd_data());
            drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rnd_data());
        end
        checks++;
        if (burst_cnt !== 16'd3 || beat_cnt !== 9'd4 || data_first !== f0 || data_last !== l0) begin
            errors++;
            $display("FAIL done_freeze: got bursts=%0d beats=%0d first=%h last=%h want bursts=3 beats=4 first=%h last=%h",
                     burst_cnt, beat_cnt, data_first, data_last, f0, l0);
        end
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, rnd_data());
        checks++;
        if (obs_snap() !== snap_t'(0)) begin
            errors++; $display("FAIL clr_beat_race: got %h want 0", obs_snap());
        end
        dn = rnd_data();
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, dn);
        checks++;
        if (data_first !== dn || beat_cnt !== 9'd1 || data_last_valid !== 1'b0) begin
            errors++;
            $display("FAIL rearm_first: got first=%h beats=%0d lv=%b want first=%h beats=1 lv=0",
                     data_first, beat_cnt, data_last_valid, dn);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL done_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_single_beat();
        logic [DW-1:0] aa;
        aa = 128'hAA;
        expected_len = 8'd0;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, aa);
        checks++;
        if (data_first !== aa || data_last !== aa || data_first_valid !== 1'b1 ||
            data_last_valid !== 1'b1 || len_error !== 1'b0 || beat_cnt !== 9'd1) begin
            errors++;
            $display("FAIL single_beat: got first=%h last=%h fv=%b lv=%b err=%b beats=%0d want AA AA 1 1 0 1",
                     data_first, data_last, data_first_valid, data_last_valid, len_error, beat_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL single_sb: got %h want %h", o, e); end
        end
    endtask

    // LAST arrives on beat 2 while 4 are expected.
    task automatic test_short_burst();
        expected_len = 8'd3;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rnd_data());
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rnd_data());
        checks++;
        if (len_error !== 1'b1 || beat_cnt !== 9'd2) begin
            errors++;
            $display("FAIL short_burst: got err=%b beats=%0d want err=1 beats=2", len_error, beat_cnt);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        checks++;
        if (obs_snap() !== snap_t'(0)) begin
            errors++; $display("FAIL short_clr: got %h want 0", obs_snap());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL short_sb: got %h want %h", o, e); end
        end
    endtask

    // Overrun flagged on the third beat before any LAST shows up.
    task automatic test_long_burst();
        expected_len = 8'd1;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rnd_data());
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rnd_data());
        checks++;
        if (len_error !== 1'b0) begin
            errors++; $display("FAIL long_beat2: got err=%b want err=0", len_error);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rnd_data());
        checks++;
        if (len_error !== 1'b1 || data_last_valid !== 1'b0 || beat_cnt !== 9'd3) begin
            errors++;
            $display("FAIL long_beat3: got err=%b lv=%b beats=%0d want err=1 lv=0 beats=3",
                     len_error, data_last_valid, beat_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL long_sb: got %h want %h", o, e); end
        end
    endtask

    task automatic test_random_stalls();
        int len, sent, cyc;
        logic v, r, en;
        for (int b = 0; b < 10; b++) begin
            expected_len = LW'($urandom_range(0, 5));
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
            len = (b % 3 == 0) ? int'($urandom_range(1, 7)) : int'(expected_len) + 1;
            sent = 0; cyc = 0;
            while (sent < len && cyc < 300) begin
                v  = ($urandom_range(0, 9) < 7);
                r  = ($urandom_range(0, 9) < 7);
                en = ($urandom_range(0, 9) < 8);
                drive_cycle(v, r, sent == len - 1, en, 1'b0, rnd_data());
                if (v && r && en) sent++;
                cyc++;
            end
            checks++;
            if (sent != len) begin
                errors++; $display("FAIL random_budget: got beats=%0d want %0d", sent, len);
            end
            repeat (4) drive_cycle(1'b1, 1'b1, $urandom_range(0, 1) == 1, 1'b1, 1'b0, rnd_data());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL random_sb: got %h want %h", o, e); end
        end
    endtask

    // Reset lands between edges mid-burst; capture restarts on the next upstream beat.
    task automatic test_reset_mid_burst();
        expected_len = 8'd4;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rnd_data());
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, rnd_data());
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_snap() !== snap_t'(0)) begin
            errors++; $display("FAIL async_rst: got %h want 0", obs_snap());
        end
        #1 rst = 1'b0;
        m = '0; m_state = 0;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, i == 2, 1'b1, 1'b0, rnd_data());
        checks++;
        if (beat_cnt !== 9'd3 || len_error !== 1'b1 || burst_cnt !== 16'd1) begin
            errors++;
            $display("FAIL post_rst_burst: got beats=%0d err=%b bursts=%0d want beats=3 err=1 bursts=1",
                     beat_cnt, len_error, burst_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rst_sb: got %h want %h", o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_done_freeze();
        test_single_beat();
        test_short_burst();
        test_long_burst();
        test_random_stalls();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
